quantize_sequencer: RTL

QUANTIZE_SEQUENCER -- requirements
Module: quantize_sequencer

---
 rtl/quantize_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/quantize_sequencer.sv
// ---------------------------------------------------------------------------
// quantize_sequencer
//
// Drains one result matrix out of a systolic array, one anti-diagonal per
// cycle. Each accumulator lane is rounded (half up), arithmetically shifted
// right and saturated to the output lane width, then registered together
// with a write strobe and the diagonal index for the SRAM write stage.
//
// Sequence after an accepted start:
//   FILL  : PIPE_DELAY cycles while the array pipeline produces the first
//           diagonal
//   DRAIN : 2*ARRAY_SIZE-1 cycles, one diagonal per cycle (index 0..2N-2)
//   DONE  : one cycle; the registered done pulse follows the last write
//
// Handshake: start is a one-cycle request with no ready. It is accepted
// only while the sequencer is IDLE (busy low). A start seen in any other
// state is dropped, and the tag and shift latched at acceptance are kept.
//
// Ports:
//   clk               rising-edge clock
//   srstn             asynchronous active-low reset
//   start             drain request
//   data_set_in       result set tag, latched on accepted start
//   shift             right-shift amount, latched on accepted start
//   acc_data          ARRAY_SIZE signed accumulator lanes (lane i at
//                     [i*ACC_DATA_WIDTH +: ACC_DATA_WIDTH])
//   sram_write_enable qualifies quantized_data and matrix_index
//   data_set          latched set tag
//   matrix_index      diagonal index of the current write
//   quantized_data    ARRAY_SIZE signed quantized lanes, same ordering
//   busy              high whenever the sequencer is not IDLE
//   done              one-cycle pulse after the final write
//   state_dbg_o       current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
module quantize_sequencer #(
  parameter int ARRAY_SIZE        = 32,
  parameter int ACC_DATA_WIDTH    = 40,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int PIPE_DELAY        = 2
) (
  input  logic                                      clk,
  input  logic                                      srstn,
  input  logic                                      start,
  input  logic [1:0]                                data_set_in,
  input  logic [4:0]                                shift,
  input  logic [ARRAY_SIZE*ACC_DATA_WIDTH-1:0]      acc_data,
  output logic                                      sram_write_enable,
  output logic [1:0]                                data_set,
  output logic [5:0]                                matrix_index,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   quantized_data,
  output logic                                      busy,
  output logic                                      done,
  output logic [1:0]                                state_dbg_o
);

  localparam int AW = ACC_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;

  localparam logic [5:0] FILL_LAST  = 6'(PIPE_DELAY - 1);
  localparam logic [5:0] DRAIN_LAST = 6'(2 * ARRAY_SIZE - 2);

  // Saturation bounds and the rounding unit, all at the widened lane width.
  localparam logic signed [AW:0] QMAX     = {{(AW - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [AW:0] QMIN     = {{(AW - OW + 2){1'b1}}, {(OW - 1){1'b0}}};
  localparam logic signed [AW:0] WIDE_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [1:0]                 set_q, set_d;
  logic [4:0]                 shift_q, shift_d;
  logic                       we_q, we_d;
  logic [5:0]                 idx_q, idx_d;
  logic [ARRAY_SIZE*OW-1:0]   qdata_q, qdata_d;
  logic                       done_q, done_d;
  logic [ARRAY_SIZE*OW-1:0]   quant_lanes;

  // One lane: widen by one bit so the rounding bias cannot overflow, add
  // half an LSB of the result, shift arithmetically, then clamp.
  function automatic logic [OW-1:0] quantize_lane(input logic [AW-1:0] lane,
                                                  input logic [4:0]    sh);
    logic signed [AW:0] wide;
    logic signed [AW:0] bias;
    logic signed [AW:0] shifted;
    logic [OW-1:0]      result;
    wide = $signed({lane[AW-1], lane});
    bias = '0;
    if (sh != 5'd0) begin
      bias = WIDE_ONE << (sh - 5'd1);
    end
    shifted = (wide + bias) >>> sh;
    if (shifted > QMAX) begin
      result = QMAX[OW-1:0];
    end else if (shifted < QMIN) begin
      result = QMIN[OW-1:0];
    end else begin
      result = shifted[OW-1:0];
    end
    return result;
  endfunction

  // Lanes are independent: each is quantized from its own slice only.
  always_comb begin
    quant_lanes = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      quant_lanes[i*OW +: OW] = quantize_lane(acc_data[i*AW +: AW], shift_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    idx_d   = '0;
    qdata_d = '0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          cnt_d   = '0;
          set_d   = data_set_in;
          shift_d = shift;
        end
      end
      S_FILL: begin
        if (cnt_q == FILL_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DRAIN: begin
        we_d    = 1'b1;
        idx_d   = cnt_q;
        qdata_d = quant_lanes;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        // Registering done here places the pulse in the cycle right after
        // the final write.
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      set_q   <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      qdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      qdata_q <= qdata_d;
      done_q  <= done_d;
    end
  end

  assign sram_write_enable = we_q;
  assign data_set          = set_q;
  assign matrix_index      = idx_q;
  assign quantized_data    = qdata_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign state_dbg_o       = state_q;

endmodule
